// File: rtl/narrow_packer_pkg.sv
// Shared types and widths for the 32-to-16 narrow packer and its helpers.
package narrow_packer_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LO    = 2'd2,
        ST_HI    = 2'd3
    } state_t;

endpackage

// File: rtl/narrow_packer_sext_fit.sv
// Combinational: word fits in 16 bits when sign-extending its low half reproduces it.
// Zero latency, no flow control; shared with the decode path.
module sext_fit
    import narrow_packer_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    output logic              o_fits
);

    logic [DATA_W-HALF_W:0] w_top;

    assign w_top  = i_word[DATA_W-1:HALF_W-1];
    assign o_fits = (&w_top) | ~(|w_top);

endmodule

// File: rtl/narrow_packer.sv
// Packs accepted 32-bit words into one short 16-bit beat (if sign-extendable) or LO/HI beats.
// First beat one cycle after acceptance; accepts only in IDLE, beats hold while out_ready is low.
module narrow_packer
    import narrow_packer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [HALF_W-1:0] out_data,
    output logic              out_short,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt_words,
    output logic [CNT_W-1:0]  cnt_short
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_word;
    logic [CNT_W-1:0]    r_cnt_words;
    logic [CNT_W-1:0]    r_cnt_short;
    logic                w_fits;
    logic                w_accept;

    sext_fit u_sext_fit (
        .i_word (in_data),
        .o_fits (w_fits)
    );

    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fits ? ST_SHORT : ST_LO;
                end
            end
            ST_SHORT: if (out_ready) w_state_nxt = ST_IDLE;
            ST_LO:    if (out_ready) w_state_nxt = ST_HI;
            ST_HI:    if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Beat fields derive only from state and the captured word, so they are stable under backpressure.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_short = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            ST_SHORT: begin
                out_valid = 1'b1;
                out_data  = r_word[HALF_W-1:0];
                out_short = 1'b1;
                out_last  = 1'b1;
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_data  = r_word[HALF_W-1:0];
            end
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = r_word[DATA_W-1:HALF_W];
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_cnt_words <= '0;
            r_cnt_short <= '0;
        end else if (w_accept) begin
            r_word      <= in_data;
            r_cnt_words <= r_cnt_words + CNT_ONE;
            if (w_fits) begin
                r_cnt_short <= r_cnt_short + CNT_ONE;
            end
        end
    end

    assign cnt_words = r_cnt_words;
    assign cnt_short = r_cnt_short;

endmodule

// File: tb/tb_narrow_packer.sv
// Directed bench for narrow_packer: a default-width instance and a 4-bit-counter instance share stimulus.
module tb_narrow_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [15:0] out_data,  out_data4;
    logic        out_short, out_short4;
    logic        out_last,  out_last4;
    logic [15:0] cnt_words, cnt_short;
    logic [3:0]  cnt_words4, cnt_short4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    narrow_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_short(out_short), .out_last(out_last),
        .out_ready(out_ready), .cnt_words(cnt_words), .cnt_short(cnt_short)
    );

    narrow_packer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_short(out_short4), .out_last(out_last4),
        .out_ready(out_ready), .cnt_words(cnt_words4), .cnt_short(cnt_short4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle; the DUT is expected to be in IDLE.
    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [15:0] d, input logic s, input logic l);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".data"},  {16'd0, out_data},  {16'd0, d});
        chk({tag, ".short"}, {31'd0, out_short}, {31'd0, s});
        chk({tag, ".last"},  {31'd0, out_last},  {31'd0, l});
        chk({tag, ".rdy"},   {31'd0, in_ready},  32'd0);
    endtask

    task automatic idle(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".rdy"},   {31'd0, in_ready},  32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;

        // Reset state, including in_ready low while rst is held
        tick();
        tick();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.data",  {16'd0, out_data},  32'd0);
        chk("rst.short", {31'd0, out_short}, 32'd0);
        chk("rst.last",  {31'd0, out_last},  32'd0);
        chk("rst.words", {16'd0, cnt_words}, 32'd0);
        chk("rst.cshort",{16'd0, cnt_short}, 32'd0);
        chk("rst.rdy",   {31'd0, in_ready},  32'd0);
        rst = 1'b0;
        #1;
        chk("rst.rdy_after", {31'd0, in_ready}, 32'd1);

        // Test 1: short word
        send(32'h0000_1234);
        beat("t1.b0", 16'h1234, 1'b1, 1'b1);
        chk("t1.words", {16'd0, cnt_words}, 32'd1);
        chk("t1.cshort",{16'd0, cnt_short}, 32'd1);
        tick();
        idle("t1.idle");

        // Test 2: long word, two beats
        send(32'h1234_5678);
        beat("t2.b0", 16'h5678, 1'b0, 1'b0);
        tick();
        beat("t2.b1", 16'h1234, 1'b0, 1'b1);
        tick();
        idle("t2.idle");
        chk("t2.words", {16'd0, cnt_words}, 32'd2);
        chk("t2.cshort",{16'd0, cnt_short}, 32'd1);

        // Test 3: fit boundaries
        do_reset();
        send(32'h0000_7FFF);
        beat("t3.a", 16'h7FFF, 1'b1, 1'b1);
        tick();
        send(32'hFFFF_8000);
        beat("t3.b", 16'h8000, 1'b1, 1'b1);
        tick();
        send(32'h0000_8000);
        beat("t3.c0", 16'h8000, 1'b0, 1'b0);
        tick();
        beat("t3.c1", 16'h0000, 1'b0, 1'b1);
        tick();
        send(32'hFFFF_7FFF);
        beat("t3.d0", 16'h7FFF, 1'b0, 1'b0);
        tick();
        beat("t3.d1", 16'hFFFF, 1'b0, 1'b1);
        tick();
        idle("t3.idle");
        chk("t3.words", {16'd0, cnt_words}, 32'd4);
        chk("t3.cshort",{16'd0, cnt_short}, 32'd2);

        // Test 4: backpressure with in_data churning
        out_ready = 1'b0;
        send(32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            beat("t4.lo", 16'hBEEF, 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        beat("t4.lo_go", 16'hBEEF, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            beat("t4.hi", 16'hDEAD, 1'b0, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        beat("t4.hi_go", 16'hDEAD, 1'b0, 1'b1);
        tick();
        idle("t4.idle");
        chk("t4.words", {16'd0, cnt_words}, 32'd5);

        // Test 5: reset while in HI drops the word
        send(32'h1234_5678);
        tick();
        beat("t5.hi", 16'h1234, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk("t5.valid", {31'd0, out_valid}, 32'd0);
        chk("t5.words", {16'd0, cnt_words}, 32'd0);
        chk("t5.cshort",{16'd0, cnt_short}, 32'd0);
        rst = 1'b0;
        #1;
        send(32'hFFFF_FFFF);
        beat("t5.b0", 16'hFFFF, 1'b1, 1'b1);
        tick();
        idle("t5.idle");
        chk("t5.words2", {16'd0, cnt_words}, 32'd1);

        // Test 6: 17 fitting words wrap the 4-bit counters to 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(32'h0000_0010 + i);
            tick();
        end
        chk("t6.words4",  {28'd0, cnt_words4}, 32'd1);
        chk("t6.cshort4", {28'd0, cnt_short4}, 32'd1);
        chk("t6.words16", {16'd0, cnt_words},  32'd17);
        chk("t6.valid4",  {31'd0, out_valid4}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
